// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage: ID/EX issue register with ALU decode, MEM/WB forwarding and load-use interlock
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_issue_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [5:0]  id_opcode,
  input  logic [5:0]  id_funct,
  input  logic [1:0]  id_aluop,
  input  logic        id_alusrc,
  input  logic        id_regdst,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        id_memwrite,
  input  logic        id_memtoreg,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [15:0] id_imm16,
  input  logic        mem_regwrite,
  input  logic        wb_regwrite,
  input  logic [4:0]  mem_rd,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] mem_result,
  input  logic [31:0] wb_result,
  input  logic        stall,
  input  logic        flush,
  output logic        ex_valid,
  output logic [31:0] srcA,
  output logic [31:0] srcB,
  output logic [3:0]  ALUControl,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_wreg,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_memtoreg
);

  logic        issued_regwrite;
  logic        issued_memread;
  logic        issued_memwrite;
  logic        issued_memtoreg;
  logic        issued_alusrc;
  logic [4:0]  issued_rs;
  logic [4:0]  issued_rt;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] imm32;
  logic [3:0]  next_alu_ctrl;
  logic [31:0] next_imm32;
  logic        hazard;
  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;
  logic        wb_hits_rs;
  logic        wb_hits_rt;

  always_comb begin
    next_alu_ctrl = 4'b1111;
    case (id_aluop)
      2'b00: next_alu_ctrl = 4'b0010;
      2'b01: next_alu_ctrl = 4'b0110;
      2'b10: begin
        case (id_funct)
          6'h20, 6'h21: next_alu_ctrl = 4'b0010;
          6'h22, 6'h23: next_alu_ctrl = 4'b0110;
          6'h24:        next_alu_ctrl = 4'b0000;
          6'h25:        next_alu_ctrl = 4'b0001;
          6'h26:        next_alu_ctrl = 4'b0011;
          6'h2A:        next_alu_ctrl = 4'b0111;
          6'h30:        next_alu_ctrl = 4'b1000;
          6'h31:        next_alu_ctrl = 4'b1001;
          default:      next_alu_ctrl = 4'b1111;
        endcase
      end
      default: begin
        case (id_opcode)
          6'h08, 6'h09: next_alu_ctrl = 4'b0010;
          6'h0A:        next_alu_ctrl = 4'b0111;
          6'h0C:        next_alu_ctrl = 4'b0000;
          6'h0D:        next_alu_ctrl = 4'b0001;
          6'h0E:        next_alu_ctrl = 4'b0011;
          default:      next_alu_ctrl = 4'b1111;
        endcase
      end
    endcase
  end

  // Logical immediates (andi/ori/xori) zero-extend; everything else sign-extends.
  always_comb begin
    next_imm32 = {{16{id_imm16[15]}}, id_imm16};
    if (id_opcode == 6'h0C || id_opcode == 6'h0D || id_opcode == 6'h0E)
      next_imm32 = {16'h0000, id_imm16};
  end

  always_comb begin
    fwd_rs = rs_val;
    if (issued_rs != 5'd0 && mem_regwrite && mem_rd == issued_rs)
      fwd_rs = mem_result;
    else if (issued_rs != 5'd0 && wb_regwrite && wb_rd == issued_rs)
      fwd_rs = wb_result;
  end

  always_comb begin
    fwd_rt = rt_val;
    if (issued_rt != 5'd0 && mem_regwrite && mem_rd == issued_rt)
      fwd_rt = mem_result;
    else if (issued_rt != 5'd0 && wb_regwrite && wb_rd == issued_rt)
      fwd_rt = wb_result;
  end

  assign wb_hits_rs = wb_regwrite && (wb_rd == issued_rs) && (issued_rs != 5'd0);
  assign wb_hits_rt = wb_regwrite && (wb_rd == issued_rt) && (issued_rt != 5'd0);

  assign srcA          = fwd_rs;
  assign srcB          = issued_alusrc ? imm32 : fwd_rt;
  assign ex_store_data = fwd_rt;

  assign ex_regwrite = ex_valid & issued_regwrite;
  assign ex_memread  = ex_valid & issued_memread;
  assign ex_memwrite = ex_valid & issued_memwrite;
  assign ex_memtoreg = ex_valid & issued_memtoreg;

  // A load in EX cannot feed ID's rs, nor rt when rt is a register operand or store data.
  assign hazard = ex_valid && issued_memread && (ex_wreg != 5'd0) &&
                  ((ex_wreg == id_rs) ||
                   ((ex_wreg == id_rt) && (!id_alusrc || id_memwrite)));

  assign id_ready = ~stall & ~hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid        <= 1'b0;
      issued_regwrite <= 1'b0;
      issued_memread  <= 1'b0;
      issued_memwrite <= 1'b0;
      issued_memtoreg <= 1'b0;
      issued_alusrc   <= 1'b0;
      issued_rs       <= 5'd0;
      issued_rt       <= 5'd0;
      ex_wreg         <= 5'd0;
      rs_val          <= 32'd0;
      rt_val          <= 32'd0;
      imm32           <= 32'd0;
      ALUControl      <= 4'd0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (stall) begin
      // Capture a producer retiring from WB so it survives after leaving the pipe.
      if (wb_hits_rs) rs_val <= wb_result;
      if (wb_hits_rt) rt_val <= wb_result;
    end else if (hazard) begin
      ex_valid <= 1'b0;
    end else if (id_valid) begin
      ex_valid        <= 1'b1;
      issued_regwrite <= id_regwrite;
      issued_memread  <= id_memread;
      issued_memwrite <= id_memwrite;
      issued_memtoreg <= id_memtoreg;
      issued_alusrc   <= id_alusrc;
      issued_rs       <= id_rs;
      issued_rt       <= id_rt;
      ex_wreg         <= id_regdst ? id_rd : id_rt;
      rs_val          <= id_rs_data;
      rt_val          <= id_rt_data;
      imm32           <= next_imm32;
      ALUControl      <= next_alu_ctrl;
    end else begin
      ex_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage: scoreboard bench for the ID/EX issue stage
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic        id_ready;
  logic [5:0]  id_opcode;
  logic [5:0]  id_funct;
  logic [1:0]  id_aluop;
  logic        id_alusrc;
  logic        id_regdst;
  logic        id_regwrite;
  logic        id_memread;
  logic        id_memwrite;
  logic        id_memtoreg;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [15:0] id_imm16;
  logic        mem_regwrite;
  logic        wb_regwrite;
  logic [4:0]  mem_rd;
  logic [4:0]  wb_rd;
  logic [31:0] mem_result;
  logic [31:0] wb_result;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic [3:0]  ALUControl;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_wreg;
  logic        ex_regwrite;
  logic        ex_memread;
  logic        ex_memwrite;
  logic        ex_memtoreg;

  alu_issue_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_opcode     (id_opcode),
    .id_funct      (id_funct),
    .id_aluop      (id_aluop),
    .id_alusrc     (id_alusrc),
    .id_regdst     (id_regdst),
    .id_regwrite   (id_regwrite),
    .id_memread    (id_memread),
    .id_memwrite   (id_memwrite),
    .id_memtoreg   (id_memtoreg),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rd         (id_rd),
    .id_rs_data    (id_rs_data),
    .id_rt_data    (id_rt_data),
    .id_imm16      (id_imm16),
    .mem_regwrite  (mem_regwrite),
    .wb_regwrite   (wb_regwrite),
    .mem_rd        (mem_rd),
    .wb_rd         (wb_rd),
    .mem_result    (mem_result),
    .wb_result     (wb_result),
    .stall         (stall),
    .flush         (flush),
    .ex_valid      (ex_valid),
    .srcA          (srcA),
    .srcB          (srcB),
    .ALUControl    (ALUControl),
    .ex_store_data (ex_store_data),
    .ex_wreg       (ex_wreg),
    .ex_regwrite   (ex_regwrite),
    .ex_memread    (ex_memread),
    .ex_memwrite   (ex_memwrite),
    .ex_memtoreg   (ex_memtoreg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        v;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [3:0]  ctl;
    logic [4:0]  wreg;
    logic [3:0]  ctrl;   // {regwrite, memread, memwrite, memtoreg}
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_issue(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] sd, input logic [3:0] ctl,
                              input logic [4:0] wreg, input logic [3:0] ctrl);
    exp_t e;
    e.tag = tag; e.v = 1'b1; e.a = a; e.b = b; e.sd = sd;
    e.ctl = ctl; e.wreg = wreg; e.ctrl = ctrl;
    sb.push_back(e);
  endtask

  task automatic expect_bubble(input string tag);
    exp_t e;
    e.tag = tag; e.v = 1'b0; e.a = '0; e.b = '0; e.sd = '0;
    e.ctl = '0; e.wreg = '0; e.ctrl = 4'b0000;
    sb.push_back(e);
  endtask

  // One clock: outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_val({e.tag, ".valid"}, {31'd0, ex_valid}, {31'd0, e.v});
      check_val({e.tag, ".ctrl"}, {28'd0, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg},
                {28'd0, e.ctrl});
      if (e.v) begin
        check_val({e.tag, ".srcA"}, srcA, e.a);
        check_val({e.tag, ".srcB"}, srcB, e.b);
        check_val({e.tag, ".store"}, ex_store_data, e.sd);
        check_val({e.tag, ".aluctl"}, {28'd0, ALUControl}, {28'd0, e.ctl});
        check_val({e.tag, ".wreg"}, {27'd0, ex_wreg}, {27'd0, e.wreg});
      end
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [1:0] aluop,
                       input logic alusrc, input logic regdst, input logic rw, input logic mr,
                       input logic mw, input logic m2r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic [15:0] imm);
    id_valid = 1'b1; id_opcode = op; id_funct = fn; id_aluop = aluop;
    id_alusrc = alusrc; id_regdst = regdst; id_regwrite = rw; id_memread = mr;
    id_memwrite = mw; id_memtoreg = m2r; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm16 = imm;
  endtask

  task automatic rtype(input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd);
    drive(6'h00, fn, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, rs, rt, rd, rsd, rtd, 16'h0);
  endtask

  task automatic itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [31:0] rsd, input logic [15:0] imm);
    drive(op, 6'h00, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, rs, rt, 5'd0, rsd, 32'h0, imm);
  endtask

  task automatic load(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] rsd,
                      input logic [15:0] imm);
    drive(6'h23, 6'h00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, rs, rt, 5'd0, rsd, 32'h0, imm);
  endtask

  task automatic store(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] rsd,
                       input logic [31:0] rtd, input logic [15:0] imm);
    drive(6'h2B, 6'h00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, rs, rt, 5'd0, rsd, rtd, imm);
  endtask

  task automatic clear_fwd();
    mem_regwrite = 1'b0; mem_rd = 5'd0; mem_result = 32'h0;
    wb_regwrite  = 1'b0; wb_rd  = 5'd0; wb_result  = 32'h0;
  endtask

  logic [5:0]  fn_tab  [11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h30, 6'h31, 6'h3F};
  logic [3:0]  fn_ctl  [11] = '{4'h2, 4'h2, 4'h6, 4'h6, 4'h0, 4'h1, 4'h3, 4'h7, 4'h8, 4'h9, 4'hF};
  logic [5:0]  op_tab  [7]  = '{6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
  logic [3:0]  op_ctl  [7]  = '{4'h2, 4'h2, 4'h7, 4'h0, 4'h1, 4'h3, 4'hF};
  logic [31:0] op_imm  [7]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0000FFFF,
                                32'h0000FFFF, 32'h0000FFFF, 32'hFFFFFFFF};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(6'h0, 6'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 16'h0);
    id_valid = 1'b0;
    clear_fwd();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst.valid", {31'd0, ex_valid}, 32'd0);
    check_val("rst.srcA", srcA, 32'd0);
    check_val("rst.srcB", srcB, 32'd0);
    check_val("rst.store", ex_store_data, 32'd0);
    check_val("rst.aluctl", {28'd0, ALUControl}, 32'd0);
    rst_n = 1'b1;
    #1;
    check_val("rst.ready", {31'd0, id_ready}, 32'd1);

    for (int i = 0; i < 11; i++) begin
      rtype(fn_tab[i], 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
      expect_issue($sformatf("rtype%0d", i), 32'd5, 32'd7, 32'd7, fn_ctl[i], 5'd3, 4'b1000);
      tick();
    end

    for (int i = 0; i < 7; i++) begin
      itype(op_tab[i], 5'd1, 5'd6, 32'h10, 16'hFFFF);
      expect_issue($sformatf("itype%0d", i), 32'h10, op_imm[i], 32'h0, op_ctl[i], 5'd6, 4'b1000);
      tick();
    end

    // Forwarding priority: MEM over WB, register 0 never forwarded.
    mem_regwrite = 1'b1; mem_rd = 5'd3; mem_result = 32'hA;
    wb_regwrite  = 1'b1; wb_rd  = 5'd3; wb_result  = 32'hB;
    rtype(6'h20, 5'd3, 5'd0, 5'd7, 32'h99, 32'h44);
    expect_issue("fwd_mem", 32'hA, 32'h44, 32'h44, 4'h2, 5'd7, 4'b1000);
    tick();
    mem_regwrite = 1'b0;
    #1;
    check_val("fwd_wb.srcA", srcA, 32'hB);
    mem_regwrite = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0;
    rtype(6'h20, 5'd0, 5'd0, 5'd7, 32'h77, 32'h44);
    expect_issue("fwd_r0", 32'h77, 32'h44, 32'h44, 4'h2, 5'd7, 4'b1000);
    tick();
    clear_fwd();

    // Load-use: one bubble, then dependent add takes the load result from MEM.
    load(5'd1, 5'd4, 32'h100, 16'h4);
    expect_issue("lw", 32'h100, 32'h4, 32'h0, 4'h2, 5'd4, 4'b1101);
    tick();
    rtype(6'h20, 5'd4, 5'd4, 5'd5, 32'hDEAD, 32'hDEAD);
    mem_regwrite = 1'b1; mem_rd = 5'd4; mem_result = 32'h1234;
    #1;
    check_val("lu.ready_lo", {31'd0, id_ready}, 32'd0);
    expect_bubble("lu_bubble");
    tick();
    check_val("lu.ready_hi", {31'd0, id_ready}, 32'd1);
    expect_issue("lu_add", 32'h1234, 32'h1234, 32'h1234, 4'h2, 5'd5, 4'b1000);
    tick();
    clear_fwd();

    // Stall while WB retires the rt producer; value must persist afterwards.
    rtype(6'h20, 5'd1, 5'd8, 5'd9, 32'd1, 32'h22);
    expect_issue("pre_stall", 32'd1, 32'h22, 32'h22, 4'h2, 5'd9, 4'b1000);
    tick();
    stall = 1'b1;
    wb_regwrite = 1'b1; wb_rd = 5'd8; wb_result = 32'h55;
    rtype(6'h22, 5'd2, 5'd3, 5'd10, 32'd20, 32'd8);
    #1;
    check_val("stall.ready", {31'd0, id_ready}, 32'd0);
    expect_issue("stall1", 32'd1, 32'h55, 32'h55, 4'h2, 5'd9, 4'b1000);
    tick();
    expect_issue("stall2", 32'd1, 32'h55, 32'h55, 4'h2, 5'd9, 4'b1000);
    tick();
    stall = 1'b0; wb_regwrite = 1'b0;
    #1;
    check_val("retired.srcB", srcB, 32'h55);
    check_val("retired.store", ex_store_data, 32'h55);
    expect_issue("post_stall", 32'd20, 32'd8, 32'd8, 4'h6, 5'd10, 4'b1000);
    tick();

    stall = 1'b1; flush = 1'b1;
    rtype(6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
    expect_bubble("flush_stall");
    tick();
    stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
    expect_bubble("idle");
    tick();

    // Flush coinciding with a load-use hazard.
    load(5'd1, 5'd4, 32'h100, 16'h4);
    expect_issue("lw2", 32'h100, 32'h4, 32'h0, 4'h2, 5'd4, 4'b1101);
    tick();
    rtype(6'h20, 5'd4, 5'd4, 5'd5, 32'h11, 32'h22);
    flush = 1'b1;
    #1;
    check_val("flush_hz.ready", {31'd0, id_ready}, 32'd0);
    expect_bubble("flush_hz");
    tick();
    flush = 1'b0;
    expect_issue("after_flush", 32'h11, 32'h22, 32'h22, 4'h2, 5'd5, 4'b1000);
    tick();

    // Store data forwarded from WB while srcB is the immediate.
    wb_regwrite = 1'b1; wb_rd = 5'd2; wb_result = 32'hBEEF;
    store(5'd1, 5'd2, 32'h1000, 32'hCAFE, 16'h8);
    expect_issue("sw", 32'h1000, 32'h8, 32'hBEEF, 4'h2, 5'd2, 4'b0010);
    tick();
    clear_fwd();

    // Asynchronous reset mid-stream.
    rtype(6'h25, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
    expect_issue("pre_rst", 32'd5, 32'd7, 32'd7, 4'h1, 5'd3, 4'b1000);
    tick();
    id_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("mrst.valid", {31'd0, ex_valid}, 32'd0);
    check_val("mrst.srcA", srcA, 32'd0);
    check_val("mrst.srcB", srcB, 32'd0);
    check_val("mrst.aluctl", {28'd0, ALUControl}, 32'd0);
    check_val("mrst.regwrite", {31'd0, ex_regwrite}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("mrst.ready", {31'd0, id_ready}, 32'd1);
    rtype(6'h2A, 5'd6, 5'd7, 5'd8, 32'h3, 32'h9);
    expect_issue("post_rst", 32'h3, 32'h9, 32'h9, 4'h7, 5'd8, 4'b1000);
    tick();

    check_val("sb.empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_issue_stage.md
# alu_issue_stage

ID/EX issue stage sitting directly upstream of the ALU in the 5-stage MIPS32 pipeline. Registers decoded operands and control from ID, decodes the 4-bit ALU control code, and selects immediates. Applies MEM/WB forwarding to produce the final srcA/srcB. Detects load-use hazards, back-pressures ID and inserts bubbles; honours a pipeline-wide stall and a branch flush.

## Interface
- (no parameters; data width fixed at 32, register index 5)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active low
- id_valid  in  1  ID presents an instruction
- id_ready  out  1  stage accepts ID instruction this cycle
- id_opcode, id_funct  in  6 each  instruction fields
- id_aluop  in  2  00 add, 01 sub, 10 R-type (funct), 11 I-type (opcode)
- id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg  in  1 each  main-decoder controls
- id_rs, id_rt, id_rd  in  5 each  register indices
- id_rs_data, id_rt_data  in  32 each  register-file read data
- id_imm16  in  16  immediate field
- mem_regwrite, wb_regwrite  in  1 each  producer write enables
- mem_rd, wb_rd  in  5 each  producer destination indices
- mem_result, wb_result  in  32 each  producer data
- stall  in  1  global freeze from downstream
- flush  in  1  squash held and incoming instruction
- ex_valid  out  1  srcA/srcB/ALUControl hold a real instruction
- srcA, srcB  out  32 each  ALU operands (forwarded, immediate-selected)
- ALUControl  out  4  ALU operation code
- ex_store_data  out  32  forwarded rt value for stores
- ex_wreg  out  5  destination register (rd if regdst else rt)
- ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  out  1 each  controls gated by ex_valid

## Operation
- ALUControl decode, registered at issue: aluop 00 -> 0010; aluop 01 -> 0110; aluop 10 by funct: 0x20/0x21 -> 0010, 0x22/0x23 -> 0110, 0x24 -> 0000, 0x25 -> 0001, 0x26 -> 0011, 0x2A -> 0111, 0x30 -> 1000 (byte add), 0x31 -> 1001 (saturating byte add), others -> 1111. aluop 11 by opcode: 0x08/0x09 -> 0010, 0x0A -> 0111, 0x0C -> 0000, 0x0D -> 0001, 0x0E -> 0011, others -> 1111.
- Immediate registered as 32 bits: zero-extended for opcodes 0x0C/0x0D/0x0E; sign-extended otherwise.
- Forwarding, combinational per operand (rs, rt): MEM match (mem_regwrite, mem_rd == index, index != 0) has priority over WB match; else the held register value. Index 0 always yields held value.
- srcA = fwd(rs); srcB = alusrc ? imm32 : fwd(rt); ex_store_data = fwd(rt).
- Load-use hazard: ex_valid & ex_memread & ex_wreg != 0 & (ex_wreg == id_rs or (ex_wreg == id_rt and id_alusrc == 0 or id_memwrite)). This drives id_ready = 0 and loads a bubble (ex_valid = 0) next cycle.
- id_ready = ~stall & ~hazard.
- States per cycle, priority order:
  - flush: ex_valid <= 0 (overrides stall).
  - stall: hold all registers. Held rs/rt values are refreshed with wb_result on WB match, so a retiring producer is not lost.
  - hazard: bubble.
  - id_valid: issue.
  - else: bubble.
- Bubble: ex_valid = 0. All ex_* controls output 0 whenever ex_valid = 0.

## Timing
- Reset (asynchronous): ex_valid, all controls, ex_wreg, held data, imm and ALUControl -> 0. Hence srcA = srcB = ex_store_data = 0, ALUControl = 0000.
- Issue latency 1 cycle: ID values sampled on edge N appear on outputs after edge N.
- Forwarded outputs react to mem_*/wb_* in the same cycle (no register).
- Load-use costs exactly one bubble. The dependent instruction issues on the following edge with the operand forwarded from MEM.
- Simultaneous flush and hazard: flush wins, id_ready still 0.
- Simultaneous stall and flush: flush wins.
- rst_n deasserted mid-stream: next issue occurs on the first edge with id_valid & id_ready.

## Test plan
- Reset: rst_n = 0 mid-run -> all outputs 0 immediately, id_ready = 1 after release.
- R-type add: rs_data = 5, rt_data = 7, funct 0x20 -> next cycle ALUControl = 0010, srcA = 5, srcB = 7, ex_wreg = rd.
- Immediate extension: ori imm 0xFFFF -> srcB = 0x0000FFFF, ALUControl = 0001. addi imm 0xFFFF -> srcB = 0xFFFFFFFF, ALUControl = 0010.
- Forward priority: rs = 3, mem_rd = wb_rd = 3, mem_result = 0xA, wb_result = 0xB -> srcA = 0xA. Repeat with rs = 0 -> srcA = held value.
- Load-use: lw $4 in EX, next add $5,$4,$4 -> id_ready = 0 for one cycle, bubble (ex_regwrite = 0), then the add issues with srcA = mem_result.
- Stall with WB retire: stall = 1 for 2 cycles while wb_rd matches rt with wb_result = 0x55, then WB leaves -> srcB = 0x55 still. Flush during stall -> ex_valid = 0 next cycle.
